ti_sbox4_pipe: RTL
==================

# ti_sbox4_pipe

Pipelined, multi-lane threshold-implementation (TI) evaluator for the 4-bit S-box, in shared form. Each lane takes a 3-share 4-bit input and applies the two quadratic stage functions G then F. A glitch-barrier register sits after each stage, so the output is the 3-share S-box result. It is the successor to the single-bit, single-stage share-function cells: all coordinates, all shares, both stages, N lanes, optional remasking, and an elastic valid/ready pipeline. It sits between the masked key-addition register and the masked permutation layer.

## Interface
- LANES, 4, number of independent S-box lanes (1..16)
- SHARES, 3, share count; only 3 is legal (elaboration error otherwise)
- REFRESH, 1, 1 = remask stage-1 register output with `rnd`; 0 = `rnd` ignored
- clk  in  1  single clock; rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  LANES*12  lane l, share s, bit b at index l*12+s*4+b
- rnd  in  LANES*8  fresh randomness, sampled on stage-1 advance; lane l uses [l*8+7:l*8]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*12  shared result, same packing as in_data
- busy  out  1  any stage holds a valid beat

## Operation
- Stage 1: each share j of G is computed from the input shares, excluding input share j (non-completeness); result goes to register s1_data with s1_valid.
- Remask (REFRESH=1), applied at s1 capture, per lane, with r0=rnd[l*8+3:l*8] and r1=rnd[l*8+7:l*8+4]: share0^=r0, share1^=r1, share2^=r0^r1. Unshared value is unchanged.
- Stage 2: F is applied to s1_data with the same non-completeness rule; result goes to register s2_data with s2_valid. out_data = s2_data and out_valid = s2_valid.
- Unshared correctness: XOR of the 3 output shares = S(XOR of the 3 input shares), S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 for x = 0..F.
- Elastic rules:
  - s2 loads when s1_valid && (!s2_valid || out_ready).
  - s1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready.
- A stage whose valid is low and receives no load clears its valid. Its data register holds its value (no clear).
- A beat is accepted on in_valid&&in_ready and consumed on out_valid&&out_ready. in_valid may fall without a handshake.
- No beat is ever dropped, duplicated or reordered.

## Timing
- Reset (rst_n=0 at an edge): s1_valid=s2_valid=0 and s1_data=s2_data=0. Hence out_valid=0, out_data=0, busy=0, in_ready=1 in the following cycle.
- Reset mid-operation discards all in-flight beats. Inputs presented during reset are not captured.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+1, if not stalled.
- Throughput: 1 beat/cycle with out_ready held high. The pipeline is full at 2 beats.
- Stall: while out_valid && !out_ready, out_data is stable. With both stages full, in_ready=0 combinationally from out_ready.
- Simultaneous events:
  - Full pipe with out_ready=1 and in_valid=1: consume, shift and accept in the same edge.
  - s2 empty and s1 full: s1 advances even with out_ready=0.
- Between the share inputs and the registers, in_data feeds only the stage-1 logic. No combinational path crosses a stage register.
- Paths to in_ready: the only combinational input-to-output path is out_ready to in_ready.

## Structure
- Package ti_s4_pkg holds:
  - the ANF term-list constants for the G and F share coordinates;
  - the S-box reference table, used by the bench model;
  - the lane/share/bit index helper functions;
  - the SHARES=3 constant.
- Sub-module ti_s4_stage (parameter FUNC = G or F) holds one lane, one stage: 12 bits in, 12 bits out, purely combinational. It is instantiated LANES×2 times. Stage registers and control live in the top module only.

## Test plan
- Reset, then one beat on lane 0 with shares (0x3,0x5,0x6) (unshared 0x0), out_ready=1, REFRESH=0 → out_valid one edge after the accept edge; XOR of the output shares = 0xC; busy drops the following cycle.
- Exhaustive: all 16 unshared values × 64 random share splits on every lane, REFRESH=1 with random rnd → every output XORs to S(x), e.g. 0x1→0x5, 0x8→0x3, 0xF→0x2. The scoreboard confirms order is preserved.
- Back-pressure: stream 10 beats, out_ready=0 for 5 cycles mid-stream → in_ready falls after 2 beats are held, out_data stays stable while stalled, all 10 results arrive in order.
- Remask check: identical in_data with rnd=0x00 versus rnd=0x21 → stage-1 shares differ, and the unshared output is the same in both cases.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight → out_valid=0 and out_data=0 next cycle, and no stale beat appears afterwards.
- Random valid/ready toggling, 10k beats, LANES=1 and LANES=16 → zero mismatches, no drops or duplicates.

Source files
------------

// File: rtl/ti_s4_pkg.sv
// Shared constants for the 3-share threshold-implementation 4-bit S-box pipeline:
// ANF term lists for the quadratic stage functions G and F, the reference S-box and index helpers.
package ti_s4_pkg;

  localparam int SHARES = 3;
  localparam int NIB_W  = 4;
  localparam int LANE_W = SHARES * NIB_W;
  localparam int RND_W  = 8;
  localparam int NPAIR  = 6;

  typedef enum logic {
    FUNC_G = 1'b0,
    FUNC_F = 1'b1
  } stage_func_e;

  // One output coordinate in ANF: constant, linear terms, quadratic pair terms.
  typedef struct packed {
    logic             cst;
    logic [NIB_W-1:0] lin;
    logic [NPAIR-1:0] quad;
  } anf_t;

  typedef anf_t [NIB_W-1:0] anf_set_t;

  // Bit naming: b3=x (msb), b2=y, b1=z, b0=w. Pair order: 0:xy 1:xz 2:xw 3:yz 4:yw 5:zw.
  // S = F(G(x)) with both stages quadratic.
  localparam anf_set_t ANF_G = {
    anf_t'{1'b0, 4'b0111, 6'b000000},  // g3 = y^z^w
    anf_t'{1'b1, 4'b0110, 6'b000000},  // g2 = 1^y^z
    anf_t'{1'b1, 4'b1010, 6'b110000},  // g1 = 1^x^z^yw^zw
    anf_t'{1'b1, 4'b0001, 6'b001011}   // g0 = 1^w^xy^xz^yz
  };

  localparam anf_set_t ANF_F = {
    anf_t'{1'b0, 4'b0111, 6'b000100},  // f3 = y^z^w^xw
    anf_t'{1'b0, 4'b1000, 6'b100000},  // f2 = x^zw
    anf_t'{1'b0, 4'b0110, 6'b000100},  // f1 = y^z^xw
    anf_t'{1'b0, 4'b0010, 6'b010000}   // f0 = z^yw
  };

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic int pair_hi(input int p);
    case (p)
      0, 1, 2: pair_hi = 3;
      3, 4:    pair_hi = 2;
      default: pair_hi = 1;
    endcase
  endfunction

  function automatic int pair_lo(input int p);
    case (p)
      0:       pair_lo = 2;
      1, 3:    pair_lo = 1;
      default: pair_lo = 0;
    endcase
  endfunction

  function automatic int bit_idx(input int lane, input int share, input int b);
    bit_idx = lane * LANE_W + share * NIB_W + b;
  endfunction

endpackage

// File: rtl/ti_sbox4_pipe_stage.sv
// One lane, one stage of the shared S-box: purely combinational 3-share evaluation of G or F.
// Output share j depends only on input shares j+1 and j+2 (mod 3).
module ti_s4_stage
  import ti_s4_pkg::*;
#(
  parameter stage_func_e FUNC = FUNC_G
) (
  input  logic [LANE_W-1:0] x_i,
  output logic [LANE_W-1:0] y_o
);

  localparam anf_set_t ANF = (FUNC == FUNC_G) ? ANF_G : ANF_F;

  logic [NIB_W-1:0] a;
  logic [NIB_W-1:0] b;
  logic             t;

  // Quadratic term uv over shares {a,b}: uv = ua*va ^ ua*vb ^ ub*va; the bb term lives in another share.
  always_comb begin
    y_o = '0;
    a   = '0;
    b   = '0;
    t   = 1'b0;
    for (int o = 0; o < SHARES; o++) begin
      a = x_i[((o + 1) % SHARES) * NIB_W +: NIB_W];
      b = x_i[((o + 2) % SHARES) * NIB_W +: NIB_W];
      for (int c = 0; c < NIB_W; c++) begin
        t = (o == 0) ? ANF[c].cst : 1'b0;
        t = t ^ (^(ANF[c].lin & a));
        for (int p = 0; p < NPAIR; p++) begin
          if (ANF[c].quad[p]) begin
            t = t ^ (a[pair_hi(p)] & a[pair_lo(p)])
                  ^ (a[pair_hi(p)] & b[pair_lo(p)])
                  ^ (b[pair_hi(p)] & a[pair_lo(p)]);
          end
        end
        y_o[o * NIB_W + c] = t;
      end
    end
  end

endmodule

// File: rtl/ti_sbox4_pipe.sv
// Multi-lane 3-share TI S-box: G stage, register (with optional remask), F stage, register,
// joined by an elastic two-entry valid/ready pipeline.
module ti_sbox4_pipe
  import ti_s4_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned SHARES  = 3,
  parameter bit          REFRESH = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*LANE_W-1:0]      in_data,
  input  logic [LANES*RND_W-1:0]       rnd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*LANE_W-1:0]      out_data,
  output logic                         busy
);

  localparam int DW = int'(LANES) * LANE_W;

  if (SHARES != 3) begin : g_bad_shares
    $error("ti_sbox4_pipe: SHARES must be 3");
  end
  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("ti_sbox4_pipe: LANES must be 1..16");
  end

  logic          s1_valid_q, s1_valid_d;
  logic          s2_valid_q, s2_valid_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic [DW-1:0] s2_data_q, s2_data_d;
  logic [DW-1:0] g_out, f_out, mask;
  logic          s1_load, s2_load;

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    logic [NIB_W-1:0] r0, r1;
    assign r0 = rnd[l*RND_W +: NIB_W];
    assign r1 = rnd[l*RND_W + NIB_W +: NIB_W];
    // Mask shares XOR to zero, so the unshared value is untouched.
    assign mask[l*LANE_W +: LANE_W] = REFRESH ? {r0 ^ r1, r1, r0} : '0;

    ti_s4_stage #(.FUNC(FUNC_G)) u_g (
      .x_i (in_data[l*LANE_W +: LANE_W]),
      .y_o (g_out[l*LANE_W +: LANE_W])
    );

    ti_s4_stage #(.FUNC(FUNC_F)) u_f (
      .x_i (s1_data_q[l*LANE_W +: LANE_W]),
      .y_o (f_out[l*LANE_W +: LANE_W])
    );
  end

  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
  assign s1_load  = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_load || (s1_valid_q && !s2_load);
    s2_valid_d = s2_load || (s2_valid_q && !out_ready);
    s1_data_d  = s1_load ? (g_out ^ mask) : s1_data_q;
    s2_data_d  = s2_load ? f_out : s2_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_data_q  <= s1_data_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule
